// File: rtl/unidad_riesgos.sv
// Hazard and sequencing controller for the 5-stage MIPS pipeline: load-use and
// branch-operand stalls, taken-branch flush, single-step gating, HALT drain and cycle count.
module unidad_riesgos #(
  parameter int DRAIN_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [4:0]       i_rs_ID,
  input  logic [4:0]       i_rt_ID,
  input  logic             i_uses_rt_ID,
  input  logic             i_branch_ID,
  input  logic             i_branch_taken_ID,
  input  logic             i_halt_ID,
  input  logic [4:0]       i_rt_EX,
  input  logic             i_mem_read_EX,
  input  logic [4:0]       i_rd_EX,
  input  logic             i_write_reg_EX,
  input  logic [4:0]       i_rd_MEM,
  input  logic             i_mem_read_MEM,
  input  logic             i_step_mode,
  input  logic             i_step,
  output logic             o_pipe_enable,
  output logic             o_stall_IF_ID,
  output logic             o_bubble_EX,
  output logic             o_flush_IF_ID,
  output logic             o_halted,
  output logic [CNT_W-1:0] o_cycle_count
);

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  state_t           state_reg;
  logic [DW-1:0]    drain_cnt_reg;
  logic             halted_reg;
  logic [CNT_W-1:0] cycle_cnt_reg;

  logic lu_hazard;
  logic br_ex_match;
  logic br_mem_match;
  logic br_hazard;
  logic stall;
  logic halt_go;

  assign lu_hazard = i_mem_read_EX && (i_rt_EX != 5'd0) &&
                     ((i_rt_EX == i_rs_ID) || (i_uses_rt_ID && (i_rt_EX == i_rt_ID)));

  // Branches compare both operands in ID, so any in-flight producer of either one blocks them.
  assign br_ex_match  = i_write_reg_EX && (i_rd_EX != 5'd0) &&
                        ((i_rd_EX == i_rs_ID) || (i_rd_EX == i_rt_ID));
  assign br_mem_match = i_mem_read_MEM && (i_rd_MEM != 5'd0) &&
                        ((i_rd_MEM == i_rs_ID) || (i_rd_MEM == i_rt_ID));
  assign br_hazard    = i_branch_ID && (br_ex_match || br_mem_match);

  assign stall   = (state_reg == RUN) && (lu_hazard || br_hazard);
  assign halt_go = (state_reg == RUN) && i_halt_ID && !stall;

  assign o_pipe_enable = (state_reg != HALTED) && (!i_step_mode || i_step);
  assign o_halted      = halted_reg;
  assign o_cycle_count = cycle_cnt_reg;

  always_comb begin
    o_stall_IF_ID = 1'b0;
    o_bubble_EX   = 1'b0;
    o_flush_IF_ID = 1'b0;
    case (state_reg)
      RUN: begin
        // A stalled branch compared stale operands, so its taken flag is not trusted.
        if (stall || halt_go) begin
          o_stall_IF_ID = 1'b1;
          o_bubble_EX   = 1'b1;
        end
        o_flush_IF_ID = i_branch_taken_ID && !stall;
      end
      DRAIN: begin
        o_stall_IF_ID = 1'b1;
        o_bubble_EX   = 1'b1;
      end
      HALTED: begin
        o_stall_IF_ID = 1'b1;
      end
      default: begin
        o_stall_IF_ID = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_reg     <= RUN;
      drain_cnt_reg <= '0;
      halted_reg    <= 1'b0;
      cycle_cnt_reg <= '0;
    end else if (o_pipe_enable) begin
      cycle_cnt_reg <= cycle_cnt_reg + CNT_W'(1);
      case (state_reg)
        RUN: begin
          if (halt_go) begin
            state_reg     <= DRAIN;
            drain_cnt_reg <= '0;
          end
        end
        DRAIN: begin
          if (drain_cnt_reg == DRAIN_LAST) begin
            state_reg  <= HALTED;
            halted_reg <= 1'b1;
          end else begin
            drain_cnt_reg <= drain_cnt_reg + DW'(1);
          end
        end
        default: begin
          state_reg <= state_reg;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_unidad_riesgos.sv
// Scoreboard bench for unidad_riesgos: directed test-plan sequences followed by
// random stimulus, checked against a cycle-level reference model.
module tb_unidad_riesgos;

  localparam int DRAIN = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rs_id, rt_id, rt_ex, rd_ex, rd_mem;
  logic        uses_rt_id, branch_id, taken_id, halt_id;
  logic        mem_read_ex, write_reg_ex, mem_read_mem, step_mode, step;
  logic        pipe_enable, stall_if_id, bubble_ex, flush_if_id, halted;
  logic [31:0] cycle_count;

  always #5 clk = ~clk;

  unidad_riesgos #(.DRAIN_CYCLES(DRAIN), .CNT_W(32)) dut (
    .i_clk(clk), .i_reset(reset),
    .i_rs_ID(rs_id), .i_rt_ID(rt_id), .i_uses_rt_ID(uses_rt_id),
    .i_branch_ID(branch_id), .i_branch_taken_ID(taken_id), .i_halt_ID(halt_id),
    .i_rt_EX(rt_ex), .i_mem_read_EX(mem_read_ex), .i_rd_EX(rd_ex),
    .i_write_reg_EX(write_reg_ex), .i_rd_MEM(rd_mem), .i_mem_read_MEM(mem_read_mem),
    .i_step_mode(step_mode), .i_step(step),
    .o_pipe_enable(pipe_enable), .o_stall_IF_ID(stall_if_id), .o_bubble_EX(bubble_ex),
    .o_flush_IF_ID(flush_if_id), .o_halted(halted), .o_cycle_count(cycle_count)
  );

  typedef struct {
    logic [4:0] rs, rt, rt_ex, rd_ex, rd_mem;
    logic uses_rt, br, taken, halt, mr_ex, wr_ex, mr_mem, smode, step, rst;
  } stim_t;

  typedef struct {
    logic pe, st, bu, fl, ha;
    logic [31:0] cnt;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int txn = 0;

  // Reference model: halt_prog is -1 while running, otherwise the number of
  // enabled edges since HALT was accepted (halted once it reaches DRAIN).
  int          halt_prog;
  logic [31:0] m_cnt;

  function automatic stim_t idle();
    stim_t s;
    s.rs = 0; s.rt = 0; s.rt_ex = 0; s.rd_ex = 0; s.rd_mem = 0;
    s.uses_rt = 0; s.br = 0; s.taken = 0; s.halt = 0; s.mr_ex = 0;
    s.wr_ex = 0; s.mr_mem = 0; s.smode = 0; s.step = 0; s.rst = 0;
    return s;
  endfunction

  function automatic bit hazard(stim_t s);
    bit lu, br;
    lu = s.mr_ex && s.rt_ex != 0 && (s.rt_ex == s.rs || (s.uses_rt && s.rt_ex == s.rt));
    br = s.br && ((s.wr_ex && s.rd_ex != 0 && (s.rd_ex == s.rs || s.rd_ex == s.rt)) ||
                  (s.mr_mem && s.rd_mem != 0 && (s.rd_mem == s.rs || s.rd_mem == s.rt)));
    return lu || br;
  endfunction

  function automatic exp_t model_out(stim_t s);
    exp_t e;
    bit running, draining, is_halted, hz;
    running   = (halt_prog < 0);
    draining  = (halt_prog >= 0) && (halt_prog < DRAIN);
    is_halted = (halt_prog == DRAIN);
    hz        = running && hazard(s);
    e.pe  = !is_halted && (!s.smode || s.step);
    e.st  = is_halted || draining || hz || (running && s.halt);
    e.bu  = draining || hz || (running && s.halt);
    e.fl  = running && !hz && s.taken;
    e.ha  = is_halted;
    e.cnt = m_cnt;
    return e;
  endfunction

  task automatic apply(input stim_t s);
    exp_t e;
    @(negedge clk);
    rs_id = s.rs; rt_id = s.rt; uses_rt_id = s.uses_rt; branch_id = s.br;
    taken_id = s.taken; halt_id = s.halt; rt_ex = s.rt_ex; mem_read_ex = s.mr_ex;
    rd_ex = s.rd_ex; write_reg_ex = s.wr_ex; rd_mem = s.rd_mem; mem_read_mem = s.mr_mem;
    step_mode = s.smode; step = s.step;
    if (s.rst) begin
      #1 reset = 1'b1;
      halt_prog = -1;
      m_cnt = 0;
      e = model_out(s);
      q.push_back(e);
      #2 reset = 1'b0;
    end else begin
      e = model_out(s);
      q.push_back(e);
    end
    @(posedge clk);
    if (e.pe) begin
      m_cnt = m_cnt + 1;
      if (halt_prog < 0) begin
        if (s.halt && !hazard(s)) halt_prog = 0;
      end else if (halt_prog < DRAIN) begin
        halt_prog = halt_prog + 1;
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (txn %0d, t=%0t)", name, act, exp, txn, $time);
    end
  endtask

  // Monitor: every cycle the outputs are settled, pop the expected response and compare.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("pipe_enable", {31'd0, pipe_enable}, {31'd0, e.pe});
        chk("stall_IF_ID", {31'd0, stall_if_id}, {31'd0, e.st});
        chk("bubble_EX",   {31'd0, bubble_ex},   {31'd0, e.bu});
        chk("flush_IF_ID", {31'd0, flush_if_id}, {31'd0, e.fl});
        chk("halted",      {31'd0, halted},      {31'd0, e.ha});
        chk("cycle_count", cycle_count, e.cnt);
        $display("txn %0d: en=%0b stall=%0b bubble=%0b flush=%0b halted=%0b count=%0d",
                 txn, pipe_enable, stall_if_id, bubble_ex, flush_if_id, halted, cycle_count);
        txn++;
      end
    end
  end

  initial begin
    stim_t s;
    bit smode_r;
    reset = 1'b1;
    halt_prog = -1;
    m_cnt = 0;
    s = idle();
    rs_id = 0; rt_id = 0; uses_rt_id = 0; branch_id = 0; taken_id = 0; halt_id = 0;
    rt_ex = 0; mem_read_ex = 0; rd_ex = 0; write_reg_ex = 0; rd_mem = 0;
    mem_read_mem = 0; step_mode = 0; step = 0;
    repeat (2) @(posedge clk);

    s = idle(); s.rst = 1; apply(s);
    apply(idle());

    // Load-use on rs, then the load has moved on
    s = idle(); s.mr_ex = 1; s.rt_ex = 3; s.rs = 3; apply(s);
    s = idle(); s.rs = 3; apply(s);

    // Taken branch after a load: stall via EX, stall via MEM load, then flush
    s = idle(); s.br = 1; s.taken = 1; s.uses_rt = 1; s.rs = 5; s.rt = 6;
    s.mr_ex = 1; s.rt_ex = 5; s.rd_ex = 5; s.wr_ex = 1; apply(s);
    s.mr_ex = 0; s.rt_ex = 0; s.rd_ex = 0; s.wr_ex = 0; s.mr_mem = 1; s.rd_mem = 5; apply(s);
    s.mr_mem = 0; s.rd_mem = 0; apply(s);

    // Register 0 never stalls; plain taken branch flushes once
    s = idle(); s.mr_ex = 1; s.rt_ex = 0; s.rs = 0; apply(s);
    s = idle(); s.br = 1; s.taken = 1; s.rs = 1; s.rt = 2; apply(s);
    apply(idle());

    // HALT held in ID behind a load-use stall, then drains to halted
    s = idle(); s.halt = 1; s.mr_ex = 1; s.rt_ex = 4; s.rs = 4; apply(s);
    s = idle(); s.halt = 1; apply(s);
    repeat (4) apply(idle());
    s = idle(); s.smode = 1; s.step = 1; apply(s);

    // Step mode from reset: idle cycles, then four single-step pulses
    s = idle(); s.smode = 1; s.rst = 1; apply(s);
    s = idle(); s.smode = 1;
    repeat (10) apply(s);
    for (int i = 0; i < 4; i++) begin
      s.step = 1; apply(s);
      s.step = 0; apply(s); apply(s);
    end

    // Asynchronous reset while draining
    s = idle(); s.rst = 1; apply(s);
    s = idle(); s.halt = 1; apply(s);
    apply(idle());
    s = idle(); s.rst = 1; apply(s);
    repeat (3) apply(idle());

    // Random traffic with small register numbers so matches are frequent
    smode_r = 0;
    for (int n = 0; n < 3000; n++) begin
      s.rs = 5'($urandom_range(0, 7)); s.rt = 5'($urandom_range(0, 7));
      s.rt_ex = 5'($urandom_range(0, 7)); s.rd_ex = 5'($urandom_range(0, 7));
      s.rd_mem = 5'($urandom_range(0, 7));
      s.uses_rt = 1'($urandom_range(0, 1)); s.br = 1'($urandom_range(0, 1));
      s.taken = 1'($urandom_range(0, 1)); s.mr_ex = 1'($urandom_range(0, 1));
      s.wr_ex = 1'($urandom_range(0, 1)); s.mr_mem = 1'($urandom_range(0, 1));
      s.halt = ($urandom_range(0, 39) == 0);
      s.rst = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 49) == 0) smode_r = !smode_r;
      s.smode = smode_r;
      s.step = 1'($urandom_range(0, 1));
      apply(s);
    end

    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/unidad_riesgos.md
# unidad_riesgos

Pipeline hazard and sequencing controller for the 5-stage MIPS core. It sits beside the forwarding unit. Its job is to handle the hazards forwarding cannot resolve:
- load-use stalls;
- branch-operand stalls in ID;
- taken-branch flush of IF/ID.

It also sequences the pipeline globally: debug single-step gating, HALT drain to a halted state, and a cycle counter for the debug unit.

## Interface
Parameters:
- DRAIN_CYCLES, 2, enabled cycles spent in DRAIN after HALT is detected (EX and MEM contents retire to WB).
- CNT_W, 32, width of cycle counter.

Ports:
- i_clk  in  1  single clock, rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_rs_ID, i_rt_ID  in  5  source registers of the instruction in ID.
- i_uses_rt_ID  in  1  ID instruction reads rt (R-type, branch, store).
- i_branch_ID  in  1  ID instruction is BEQ/BNE/JR (operands compared in ID).
- i_branch_taken_ID  in  1  ID branch/jump resolved taken.
- i_halt_ID  in  1  ID instruction is HALT.
- i_rt_EX  in  5  destination of the load in EX.
- i_mem_read_EX  in  1  EX instruction is a load.
- i_rd_EX  in  5  destination register of the EX instruction.
- i_write_reg_EX  in  1  EX instruction writes a register.
- i_rd_MEM  in  5  destination register of the MEM instruction.
- i_mem_read_MEM  in  1  MEM instruction is a load.
- i_step_mode  in  1  debug single-step mode.
- i_step  in  1  one-cycle pulse: advance one cycle in step mode.
- o_pipe_enable  out  1  global write enable for PC and all pipeline registers.
- o_stall_IF_ID  out  1  hold PC and IF/ID.
- o_bubble_EX  out  1  load NOP into ID/EX.
- o_flush_IF_ID  out  1  load NOP into IF/ID.
- o_halted  out  1  registered; pipeline halted.
- o_cycle_count  out  CNT_W  registered count of enabled cycles.

## Operation
- FSM states: RUN, DRAIN, HALTED. The state is registered.
- Enable: o_pipe_enable = (state != HALTED) && (!i_step_mode || i_step). This output is combinational.
- Load-use (LU) hazard: i_mem_read_EX && i_rt_EX != 0 && (i_rt_EX == i_rs_ID || (i_uses_rt_ID && i_rt_EX == i_rt_ID)).
- Branch hazard (BR): i_branch_ID && any nonzero operand match against either of:
  - i_rd_EX when i_write_reg_EX;
  - i_rd_MEM when i_mem_read_MEM.
- STALL = (LU || BR) in RUN.
  - STALL -> o_stall_IF_ID=1, o_bubble_EX=1, o_flush_IF_ID=0.
  - A stall overrides a taken branch, because the comparison used stale operands.
- Taken branch without STALL in RUN: o_flush_IF_ID=1.
- HALT in ID, RUN, no STALL, on an enabled edge: go to DRAIN with the drain counter = 0.
  - In that cycle o_stall_IF_ID=1 and o_bubble_EX=1, so HALT becomes a bubble.
  - If STALL is also active, HALT waits in ID until STALL clears.
- DRAIN:
  - o_stall_IF_ID=1, o_bubble_EX=1, o_flush_IF_ID=0.
  - Hazard inputs are ignored.
  - The counter increments on each enabled edge; on the enabled edge where it equals DRAIN_CYCLES-1, go to HALTED.
- HALTED:
  - o_halted=1, o_pipe_enable=0, o_stall_IF_ID=1, o_bubble_EX=0, o_flush_IF_ID=0.
  - Only reset leaves HALTED.
- Cycle counter: increments on every edge with o_pipe_enable=1, in RUN and DRAIN. It wraps modulo 2^CNT_W. It is frozen in HALTED.
- Hazard outputs are computed every cycle regardless of enable. They take effect only when o_pipe_enable=1.

## Timing
- Reset (asynchronous, immediate) sets state=RUN, drain counter=0, o_halted=0, o_cycle_count=0.
  - With all inputs low, the combinational outputs after reset are: o_pipe_enable=1, o_stall_IF_ID=0, o_bubble_EX=0, o_flush_IF_ID=0.
- Reset in mid-DRAIN or in HALTED returns to RUN on the same asynchronous assertion.
- o_stall_IF_ID, o_bubble_EX, o_flush_IF_ID and o_pipe_enable have zero-cycle latency (combinational from inputs and state).
- Stall lengths:
  - LU stalls exactly 1 enabled cycle (the load moves to MEM).
  - BR on an EX ALU result stalls 1 cycle.
  - BR on an EX load stalls 2 cycles: BR via EX, then BR via MEM load.
- HALT detection to o_halted=1 takes 1 + DRAIN_CYCLES enabled edges. In free-run this is 3 clock edges.
- Step mode:
  - With i_step=0, no state or counter changes occur.
  - Each i_step pulse advances exactly one pipeline cycle.
  - A step pulse while HALTED has no effect.
- Register 0 never causes a hazard.

## Test plan
- Load-use: `lw $3` in EX (i_mem_read_EX=1, i_rt_EX=3) and `add` in ID with rs=3 -> one cycle of stall=1, bubble=1, flush=0; the next cycle with the load gone -> all hazard outputs 0.
- Branch after load: i_branch_ID=1, rs=5, with the EX load writing $5 -> 2 consecutive stall cycles. With i_branch_taken_ID=1 throughout, flush=0 during both stalls and flush=1 on the third cycle.
- Zero register: a load to $0 with ID rs=0 -> no stall. A taken branch with no hazard -> flush=1 for 1 cycle.
- HALT drain: i_halt_ID=1 in RUN -> state sequence RUN, DRAIN, DRAIN, HALTED; o_halted rises on edge 3; o_pipe_enable=0 afterwards; o_cycle_count stops at its value +3.
- Step mode: i_step_mode=1 with 10 idle cycles -> o_cycle_count stays at 0. Then 4 i_step pulses -> o_cycle_count=4, and o_pipe_enable is high only during the pulses.
- Asynchronous reset asserted mid-DRAIN between clock edges -> o_halted=0, state=RUN and o_cycle_count=0 immediately; normal operation resumes on the next edge.
